// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Show-ahead receive FIFO between the UART receiver and the bus.
//            Stores {frame_err, byte} entries, reports the fill level, a
//            sticky overrun flag and a threshold interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int ADDR_W = 4,
   parameter int THRESH = 8
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_byte,
   input  logic              i_rx_frame_err,
   input  logic              i_rd_en,
   input  logic              i_clr_ovr,
   output logic [31:0]       o_rd_data,
   output logic [ADDR_W:0]   o_count,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_overrun,
   output logic              o_rx_irq
);

   localparam int              c_DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W+1)'(c_DEPTH);
   localparam logic [ADDR_W:0] c_THRESH   = (ADDR_W+1)'(THRESH);

   logic [8:0]        r_mem [c_DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overrun;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL_CNT);

   // A pop is only honoured when data is held; a push into a full FIFO is
   // accepted only when a pop in the same cycle frees the slot.
   assign w_pop  = i_rd_en && !w_empty;
   assign w_push = i_rx_valid && (!w_full || i_rd_en);
   assign w_drop = i_rx_valid && w_full && !i_rd_en;

   // Storage array write; deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_rx_frame_err, i_rx_byte};
      end
   end

   // Pointers and occupancy counter; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
         r_overrun <= 1'b0;
      end
   end

   // Show-ahead head entry, zero-extended, forced to zero when empty.
   always_comb begin
      o_rd_data = 32'd0;
      if (!w_empty) begin
         o_rd_data = {23'd0, r_mem[r_rd_ptr]};
      end
   end

   assign o_count   = r_count;
   assign o_empty   = w_empty;
   assign o_full    = w_full;
   assign o_overrun = r_overrun;
   assign o_rx_irq  = (r_count >= c_THRESH) || r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo. Stimulus pushes expected
//            words into a queue; a monitor pops and compares on every read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int c_DEPTH  = 16;
   localparam int c_THRESH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_frame_err;
   logic        rd_en;
   logic        clr_ovr;
   logic [31:0] rd_data;
   logic [4:0]  count;
   logic        empty;
   logic        full;
   logic        overrun;
   logic        rx_irq;

   logic [31:0] exp_q[$];
   bit          m_ovr = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.ADDR_W(4), .THRESH(c_THRESH)) dut (
      .clk            (clk),
      .i_rst_n        (rst_n),
      .i_rx_valid     (rx_valid),
      .i_rx_byte      (rx_byte),
      .i_rx_frame_err (rx_frame_err),
      .i_rd_en        (rd_en),
      .i_clr_ovr      (clr_ovr),
      .o_rd_data      (rd_data),
      .o_count        (count),
      .o_empty        (empty),
      .o_full         (full),
      .o_overrun      (overrun),
      .o_rx_irq       (rx_irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every bus read compares the presented head word with the scoreboard.
   always @(negedge clk) begin
      if (rst_n && rd_en) begin
         if (exp_q.size() > 0) begin
            chk("pop_data", rd_data, exp_q.pop_front());
         end else begin
            chk("pop_when_empty", rd_data, 32'd0);
         end
      end
   end

   task automatic check_state(input string tag);
      int sz;
      logic [31:0] head;
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : 32'd0;
      chk({tag, "_count"},   {27'd0, count},   sz);
      chk({tag, "_empty"},   {31'd0, empty},   {31'd0, (sz == 0)});
      chk({tag, "_full"},    {31'd0, full},    {31'd0, (sz == c_DEPTH)});
      chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
      chk({tag, "_irq"},     {31'd0, rx_irq},  {31'd0, ((sz >= c_THRESH) || m_ovr)});
      chk({tag, "_head"},    rd_data,          head);
   endtask

   // One clock of stimulus; the scoreboard is updated after the edge, once the
   // monitor has already consumed any pop from this cycle.
   task automatic step(input string tag, input bit v, input logic [7:0] b,
                       input bit e, input bit rd, input bit clr);
      bit dropped;
      rx_valid     = v;
      rx_byte      = b;
      rx_frame_err = e;
      rd_en        = rd;
      clr_ovr      = clr;
      @(negedge clk);
      @(posedge clk);
      dropped = 1'b0;
      if (v) begin
         if (exp_q.size() < c_DEPTH) exp_q.push_back({23'd0, e, b});
         else dropped = 1'b1;
      end
      if (dropped) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      #1;
      rx_valid     = 1'b0;
      rx_byte      = 8'h00;
      rx_frame_err = 1'b0;
      rd_en        = 1'b0;
      clr_ovr      = 1'b0;
      check_state(tag);
   endtask

   initial begin
      rst_n        = 1'b0;
      rx_valid     = 1'b0;
      rx_byte      = 8'h00;
      rx_frame_err = 1'b0;
      rd_en        = 1'b0;
      clr_ovr      = 1'b0;
      #12;
      check_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: three pushes, three show-ahead pops
      step("t1_push", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      step("t1_push", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      step("t1_push", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("t1_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step("t1_pop_empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 2: fill to DEPTH, watch irq threshold, overflow drop, drain
      for (int i = 0; i < 16; i++) step("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step("t2_drop", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step("t2_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step("t2_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // 3: push and pop together while full
      for (int i = 0; i < 16; i++) step("t3_fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      step("t3_both", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step("t3_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 4: framing-error flag in bit 8
      step("t4_err", 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
      step("t4_ok",  1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      step("t4_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step("t4_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 5: overrun set wins over clear, then plain clear
      for (int i = 0; i < 16; i++) step("t5_fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      step("t5_drop",     1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      step("t5_drop_clr", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
      step("t5_clr",      1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step("t5_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // push and pop together while empty: pop ignored, push lands
      step("t5_empty_both", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      step("t5_pop",        1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      m_ovr = 1'b0;
      check_state("t6_async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("t6_push", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      step("t6_pop",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
